bcd_hour_counter: RTL and testbench
===================================

// Module: bcd_hour_counter
// PURPOSE
//  Next-generation hour counter for the digital clock: one BCD hour state, shown in 12h or 24h form.
//  Counts up or down on a 1-cycle enable tick, flags PM, and emits a day carry.
//  Sits after the minutes counter (en = minutes carry) and feeds the hour digits of the display mux.
//  Up/down and the optional load port serve the time-set UI.
// PARAMETERS
//  INIT_HOUR   8'h00  reset hour in 24h BCD {tens,units}; must be 00..23 (00 displays as 12 AM)
//  DEFAULT_24H 1'b0   reserved compile-time default for the board-level mode strap; no internal effect
// PORTS
//  clk        in   1  system clock; all state on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  en         in   1  count tick, 1-cycle pulse (1 Hz or minutes carry)
//  dec        in   1  direction when en=1: 0 up, 1 down
//  mode_24    in   1  display mode: 1 = 24h (00..23), 0 = 12h (01..12 + pm)
//  load       in   1  load strobe (HOUR_LOAD_EN only)
//  load_tens  in   4  BCD tens to load, in the current display mode
//  load_units in   4  BCD units to load
//  load_pm    in   1  PM flag for a 12h-mode load
//  tens       out  4  displayed BCD tens
//  units      out  4  displayed BCD units
//  pm         out  1  1 when internal hour is 12..23, in both modes
//  cout       out  1  day carry, combinational
//  load_err   out  1  registered 1-cycle pulse: rejected load
// BEHAVIOUR
//  - State: one 8-bit BCD register h24, range 00..23, always kept valid.
//  - Reset (async, rst_n=0): h24 = INIT_HOUR; load_err = 0.
//    With default INIT_HOUR: tens/units = 1/2 in 12h mode, 0/0 in 24h mode; pm = 0.
//  - Display, combinational from h24 and mode_24:
//    - 24h mode: digits = h24.
//    - 12h mode: 00 -> 12; 01..12 unchanged; 13..23 -> h24-12 (13->01, 19->07, 20->08, 23->11).
//  - mode_24 changes the display only; h24 is untouched, so there is no conversion latency.
//  - Up count (en=1, dec=0): units +1; units 9 -> 0 with tens +1; 23 -> 00.
//  - Down count (en=1, dec=1): units -1; units 0 -> 9 with tens -1; 00 -> 23.
//  - en=0: hold. dec is ignored when en=0.
//  - cout = en & ~dec & (h24 == 8'h23), in both modes.
//    Asserted in the cycle before the wrap to 00; never asserted on a down count.
//  - Priority in one cycle: load > en. A valid load in the same cycle as en discards the tick.
//  - pm is combinational: h24 >= 12.
//    In 12h mode pm therefore toggles on 11->12 and on 11PM->12AM, up or down.
//  - Out-of-range INIT_HOUR is a configuration error; the bench checks for it with an assertion.
// CONFIGURATION
//  - Macro HOUR_LOAD_EN defined:
//    - load=1 samples load_tens, load_units and load_pm under the current mode_24.
//    - Valid loads: 24h 00..23; 12h 01..12 with units <= 9.
//    - Valid load: h24 takes the converted value on the next edge.
//      12h conversion: 12 AM -> 00; 12 PM -> 12; n PM -> n+12; n AM -> n.
//    - Invalid load: h24 holds, the en tick in that cycle is also dropped, and load_err = 1 for one cycle.
//  - Macro undefined: load, load_tens, load_units and load_pm are ignored; load_err is tied to 0.
// TESTING
//  1. Reset with default params, mode_24=0 -> tens/units = 1/2, pm=0.
//     Release reset, 12 en pulses up -> 01..11 then 12 with pm=1 (12 PM).
//  2. mode_24=1, h24=22, en up x2 -> 23 with cout=1 during the second pulse, then 00 with cout=0.
//     Mid-run, toggle mode_24 at h24=15: display 15 <-> 03 PM, no state change.
//  3. dec=1 from 00 (12h: 12 AM), one en -> h24=23 (12h: 11 PM, pm=1), cout stays 0.
//     Then down through 10 -> 09 -> 08 checks the BCD borrow.
//  4. HOUR_LOAD_EN, 12h mode, load 12 AM -> 00; load 07 PM -> 19.
//     Load 13 or 00 in 12h, or 24 / units=A in 24h -> h24 holds, load_err pulses for exactly 1 cycle.
//  5. Valid load and en in the same cycle -> loaded value only, no increment.
//     Invalid load with en -> hold.
//  6. Assert rst_n mid-count (async, between edges) -> outputs return to INIT_HOUR immediately.
//     Without HOUR_LOAD_EN, load=1 -> no effect and load_err=0.

Source files
------------

// File: rtl/bcd_hour_counter.sv
// BCD hour counter: one 24h state register shown in 12h or 24h form, up/down tick, PM flag, day carry.
// Optional time-set load port is compiled in when HOUR_LOAD_EN is defined.
module bcd_hour_counter #(
    parameter logic [7:0] INIT_HOUR   = 8'h00,
    parameter logic       DEFAULT_24H = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dec,
    input  logic       mode_24,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    input  logic       load_pm,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       pm,
    output logic       cout,
    output logic       load_err
);

    logic [7:0] h24;
    logic [7:0] h24_next;
    logic [7:0] step_val;
    logic [4:0] hour_bin;
    logic [4:0] disp_bin;

    // Binary 0..23 back to packed BCD {tens,units}.
    function automatic logic [7:0] bin_to_bcd(input logic [4:0] b);
        logic [3:0] t;
        t = (b >= 5'd20) ? 4'd2 : (b >= 5'd10) ? 4'd1 : 4'd0;
        return {t, 4'(b - 5'(t) * 5'd10)};
    endfunction

    // The board strap default has no internal effect.
    logic unused_cfg;
    assign unused_cfg = DEFAULT_24H;

    assign hour_bin = 5'(h24[7:4]) * 5'd10 + 5'(h24[3:0]);

    always_comb begin
        disp_bin = hour_bin;
        if (!mode_24) begin
            if (hour_bin == 5'd0)
                disp_bin = 5'd12;
            else if (hour_bin > 5'd12)
                disp_bin = hour_bin - 5'd12;
        end
    end

    assign {tens, units} = bin_to_bcd(disp_bin);
    assign pm            = (h24 >= 8'h12);
    assign cout          = en & ~dec & (h24 == 8'h23);

    always_comb begin
        step_val = h24;
        if (dec) begin
            if (h24 == 8'h00)
                step_val = 8'h23;
            else if (h24[3:0] == 4'd0)
                step_val = {h24[7:4] - 4'd1, 4'd9};
            else
                step_val = {h24[7:4], h24[3:0] - 4'd1};
        end else begin
            if (h24 == 8'h23)
                step_val = 8'h00;
            else if (h24[3:0] == 4'd9)
                step_val = {h24[7:4] + 4'd1, 4'd0};
            else
                step_val = {h24[7:4], h24[3:0] + 4'd1};
        end
    end

`ifdef HOUR_LOAD_EN
    logic [6:0] ld_bin;
    logic [4:0] ld_hour;
    logic       digits_ok;
    logic       load_valid;
    logic       load_err_next;

    assign ld_bin    = 7'(load_tens) * 7'd10 + 7'(load_units);
    assign digits_ok = (load_tens <= 4'd9) && (load_units <= 4'd9);

    // Loaded digits are interpreted in whichever display mode is active.
    always_comb begin
        load_valid = 1'b0;
        ld_hour    = 5'd0;
        if (mode_24) begin
            load_valid = digits_ok && (ld_bin <= 7'd23);
            ld_hour    = ld_bin[4:0];
        end else begin
            load_valid = digits_ok && (ld_bin >= 7'd1) && (ld_bin <= 7'd12);
            ld_hour    = ((ld_bin == 7'd12) ? 5'd0 : ld_bin[4:0]) + (load_pm ? 5'd12 : 5'd0);
        end
    end

    // A load, valid or not, always claims the cycle and drops any tick.
    always_comb begin
        h24_next      = h24;
        load_err_next = 1'b0;
        if (load) begin
            if (load_valid)
                h24_next = bin_to_bcd(ld_hour);
            else
                load_err_next = 1'b1;
        end else if (en) begin
            h24_next = step_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            load_err <= 1'b0;
        else
            load_err <= load_err_next;
    end
`else
    logic unused_load;
    assign unused_load = ^{load, load_tens, load_units, load_pm};

    always_comb begin
        h24_next = h24;
        if (en)
            h24_next = step_val;
    end

    assign load_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            h24 <= INIT_HOUR;
        else
            h24 <= h24_next;
    end

endmodule

// File: tb/tb_bcd_hour_counter.sv
// Self-checking bench for bcd_hour_counter: directed time-set scenarios plus random ticks/loads
// against an integer-hour model; load scenarios follow HOUR_LOAD_EN.
module tb_bcd_hour_counter;

    localparam logic [7:0] INIT     = 8'h00;
    localparam int         INIT_INT = 10 * int'(INIT[7:4]) + int'(INIT[3:0]);
`ifdef HOUR_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dec = 1'b0;
    logic       mode_24 = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_tens = 4'd0;
    logic [3:0] load_units = 4'd0;
    logic       load_pm = 1'b0;
    logic [3:0] tens;
    logic [3:0] units;
    logic       pm;
    logic       cout;
    logic       load_err;

    int checks = 0;
    int failures = 0;
    int m_hour = INIT_INT;
    bit m_err = 1'b0;
    logic cs;

    bcd_hour_counter #(.INIT_HOUR(INIT), .DEFAULT_24H(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dec(dec), .mode_24(mode_24),
        .load(load), .load_tens(load_tens), .load_units(load_units), .load_pm(load_pm),
        .tens(tens), .units(units), .pm(pm), .cout(cout), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Load acceptance from the human rules: 24h 0..23, 12h 1..12 with AM/PM.
    function automatic bit load_ok(input bit m24, input int t, input int u, input bit p, output int h);
        int n;
        n = t * 10 + u;
        h = 0;
        if (t > 9 || u > 9) return 1'b0;
        if (m24) begin
            h = n;
            return n <= 23;
        end
        if (n < 1 || n > 12) return 1'b0;
        h = (n % 12) + (p ? 12 : 0);
        return 1'b1;
    endfunction

    always @(negedge rst_n) begin
        m_hour = INIT_INT;
        m_err  = 1'b0;
    end

    always @(posedge clk) begin
        int h;
        if (rst_n) begin
            m_err = 1'b0;
            if (LOAD_EN && load) begin
                if (load_ok(mode_24, int'(load_tens), int'(load_units), load_pm, h))
                    m_hour = h;
                else
                    m_err = 1'b1;
            end else if (en) begin
                m_hour = dec ? (m_hour + 23) % 24 : (m_hour + 1) % 24;
            end
        end
    end

    always @(negedge clk) begin
        int disp;
        disp = mode_24 ? m_hour : ((m_hour % 12 == 0) ? 12 : m_hour % 12);
        chk("cyc_tens", int'(tens), disp / 10);
        chk("cyc_units", int'(units), disp % 10);
        chk("cyc_pm", int'(pm), int'(m_hour >= 12));
        chk("cyc_cout", int'(cout), int'(en && !dec && m_hour == 23));
        chk("cyc_load_err", int'(load_err), int'(m_err));
    end

    // Inputs applied at posedge+1; returns at the next posedge+1 with cout sampled mid-cycle.
    task automatic drive(input logic e, input logic d, input logic l, input logic [3:0] lt,
                         input logic [3:0] lu, input logic lp, output logic cout_s);
        en = e; dec = d; load = l; load_tens = lt; load_units = lu; load_pm = lp;
        @(negedge clk);
        #1;
        cout_s = cout;
        @(posedge clk);
        #1;
        en = 1'b0; dec = 1'b0; load = 1'b0; load_pm = 1'b0;
    endtask

    task automatic tick(input logic d);
        drive(1'b1, d, 1'b0, 4'd0, 4'd0, 1'b0, cs);
    endtask

    task automatic disp_chk(input string name, input int t, input int u, input int p);
        chk({name, "_tens"}, int'(tens), t);
        chk({name, "_units"}, int'(units), u);
        chk({name, "_pm"}, int'(pm), p);
    endtask

    initial begin
        assert (INIT[7:4] <= 4'd2 && INIT[3:0] <= 4'd9 && INIT <= 8'h23)
            else $error("INIT_HOUR out of range");

        #12;
        disp_chk("reset_12h", 1, 2, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) tick(1'b0);
        disp_chk("up_11am", 1, 1, 0);
        tick(1'b0);
        disp_chk("up_12pm", 1, 2, 1);

        for (int i = 0; i < 3; i++) tick(1'b0);
        mode_24 = 1'b1;
        #1 disp_chk("h15_24h", 1, 5, 1);
        mode_24 = 1'b0;
        #1 disp_chk("h15_12h", 0, 3, 1);
        mode_24 = 1'b1;
        for (int i = 0; i < 7; i++) tick(1'b0);
        disp_chk("h22", 2, 2, 1);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, cs);
        chk("cout_at_22", int'(cs), 0);
        disp_chk("h23", 2, 3, 1);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, cs);
        chk("cout_at_23", int'(cs), 1);
        disp_chk("wrap_00", 0, 0, 0);
        chk("cout_idle", int'(cout), 0);

        mode_24 = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, cs);
        chk("cout_down_wrap", int'(cs), 0);
        disp_chk("down_11pm", 1, 1, 1);
        mode_24 = 1'b1;
        for (int i = 0; i < 13; i++) tick(1'b1);
        disp_chk("down_10", 1, 0, 0);
        tick(1'b1);
        disp_chk("down_09", 0, 9, 0);
        tick(1'b1);
        disp_chk("down_08", 0, 8, 0);

`ifdef HOUR_LOAD_EN
        mode_24 = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 1'b0, cs);
        disp_chk("load_12am", 1, 2, 0);
        chk("load_12am_err", int'(load_err), 0);
        drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 1'b1, cs);
        disp_chk("load_7pm", 0, 7, 1);
        mode_24 = 1'b1;
        #1 disp_chk("load_7pm_24h", 1, 9, 1);
        mode_24 = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 4'd1, 4'd3, 1'b0, cs);
        chk("bad13_err", int'(load_err), 1);
        disp_chk("bad13_hold", 0, 7, 1);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, cs);
        chk("err_one_cycle", int'(load_err), 0);
        drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, cs);
        chk("bad00_err", int'(load_err), 1);
        mode_24 = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 4'd2, 4'd4, 1'b0, cs);
        chk("bad24_err", int'(load_err), 1);
        drive(1'b0, 1'b0, 1'b1, 4'd0, 4'hA, 1'b0, cs);
        chk("badA_err", int'(load_err), 1);
        disp_chk("bad_hold", 1, 9, 1);
        drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0, cs);
        disp_chk("load_wins", 0, 5, 0);
        drive(1'b1, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0, cs);
        disp_chk("bad_load_en_hold", 0, 5, 0);
        chk("bad_load_en_err", int'(load_err), 1);
`else
        drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd5, 1'b1, cs);
        disp_chk("load_ignored", 0, 8, 0);
        chk("load_err_tied", int'(load_err), 0);
`endif

        mode_24 = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0);
        #3 rst_n = 1'b0;
        #1 disp_chk("async_reset", 1, 2, 0);
        chk("async_reset_err", int'(load_err), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) mode_24 = ~mode_24;
            if ($urandom_range(0, 7) == 0)
                drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1,
                      4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 2)),
                      4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 9)),
                      $urandom_range(0, 1) == 1, cs);
            else
                drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 1'b0,
                      4'd0, 4'd0, 1'b0, cs);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
